// File: rtl/vpe_arbiter.sv
// Round-robin arbiter sharing one vector PE among NUM_REQ requesters.
// Latches the winner's operands, waits for the VPE result (with timeout) and routes it back.
module vpe_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DIM_SIZE   = 128,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*DIM_SIZE*DATA_WIDTH-1:0] req_vec1,
    input  logic [NUM_REQ*DIM_SIZE*DATA_WIDTH-1:0] req_vec2,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]          req_sca1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]          req_sca2,
    input  logic [NUM_REQ-1:0]                     req_mode,
    output logic [DIM_SIZE*DATA_WIDTH-1:0]         vpe_vec1,
    output logic [DIM_SIZE*DATA_WIDTH-1:0]         vpe_vec2,
    output logic [DATA_WIDTH-1:0]                  vpe_sca1,
    output logic [DATA_WIDTH-1:0]                  vpe_sca2,
    output logic                                   vpe_mode,
    output logic                                   vpe_valid_o,
    input  logic                                   vpe_ready_i,
    input  logic [DIM_SIZE*DATA_WIDTH-1:0]         res_vpe_vec,
    input  logic [DATA_WIDTH-1:0]                  res_vpe_sca,
    input  logic                                   vpe_valid_i,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic [DIM_SIZE*DATA_WIDTH-1:0]         rsp_vec,
    output logic [DATA_WIDTH-1:0]                  rsp_sca,
    output logic                                   busy,
    output logic                                   timeout_err
);

    localparam int unsigned VEC_W = DIM_SIZE * DATA_WIDTH;
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef logic [PTR_W-1:0]   ptr_t;
    typedef logic [PTR_W:0]     cand_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [NUM_REQ-1:0] req_t;

    localparam ptr_t  LAST_IDX  = ptr_t'(NUM_REQ - 1);
    localparam cand_t NUM_REQ_C = cand_t'(NUM_REQ);
    localparam cnt_t  CNT_LAST  = cnt_t'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e            state_q, state_d;
    ptr_t              ptr_q, ptr_d;
    ptr_t              owner_q, owner_d;
    cnt_t              cnt_q, cnt_d;
    logic              terr_q, terr_d;

    logic [VEC_W-1:0]      vec1_q, vec1_d;
    logic [VEC_W-1:0]      vec2_q, vec2_d;
    logic [DATA_WIDTH-1:0] sca1_q, sca1_d;
    logic [DATA_WIDTH-1:0] sca2_q, sca2_d;
    logic                  mode_q, mode_d;

    req_t                  rsp_valid_q, rsp_valid_d;
    logic [VEC_W-1:0]      rsp_vec_q, rsp_vec_d;
    logic [DATA_WIDTH-1:0] rsp_sca_q, rsp_sca_d;

    logic                  found;
    ptr_t                  winner;
    cand_t                 cand;
    ptr_t                  next_owner;

    logic [VEC_W-1:0]      sel_vec1, sel_vec2;
    logic [DATA_WIDTH-1:0] sel_sca1, sel_sca2;
    logic                  sel_mode;

    // Winner: first requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + cand_t'(k);
            if (cand >= NUM_REQ_C) begin
                cand = cand - NUM_REQ_C;
            end
            if (!found && req_valid[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        sel_vec1 = '0;
        sel_vec2 = '0;
        sel_sca1 = '0;
        sel_sca2 = '0;
        sel_mode = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ptr_t'(i)) begin
                sel_vec1 = req_vec1[i*VEC_W +: VEC_W];
                sel_vec2 = req_vec2[i*VEC_W +: VEC_W];
                sel_sca1 = req_sca1[i*DATA_WIDTH +: DATA_WIDTH];
                sel_sca2 = req_sca2[i*DATA_WIDTH +: DATA_WIDTH];
                sel_mode = req_mode[i];
            end
        end
    end

    // Accept pulse is only offered in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !rst && (state_q == StIdle) && found && (winner == ptr_t'(i));
        end
    end

    assign next_owner = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        terr_d      = terr_q;
        vec1_d      = vec1_q;
        vec2_d      = vec2_q;
        sca1_d      = sca1_q;
        sca2_d      = sca2_q;
        mode_d      = mode_q;
        rsp_valid_d = '0;
        rsp_vec_d   = rsp_vec_q;
        rsp_sca_d   = rsp_sca_q;

        case (state_q)
            StIdle: begin
                if (found) begin
                    vec1_d  = sel_vec1;
                    vec2_d  = sel_vec2;
                    sca1_d  = sel_sca1;
                    sca2_d  = sel_sca2;
                    mode_d  = sel_mode;
                    owner_d = winner;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (vpe_ready_i) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // A result on the last allowed cycle still wins over the timeout.
                if (vpe_valid_i) begin
                    rsp_vec_d   = res_vpe_vec;
                    rsp_sca_d   = res_vpe_sca;
                    rsp_valid_d = req_t'(1) << owner_q;
                    ptr_d       = next_owner;
                    state_d     = StIdle;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d  = 1'b1;
                    ptr_d   = next_owner;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            terr_q      <= 1'b0;
            vec1_q      <= '0;
            vec2_q      <= '0;
            sca1_q      <= '0;
            sca2_q      <= '0;
            mode_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_vec_q   <= '0;
            rsp_sca_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            terr_q      <= terr_d;
            vec1_q      <= vec1_d;
            vec2_q      <= vec2_d;
            sca1_q      <= sca1_d;
            sca2_q      <= sca2_d;
            mode_q      <= mode_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_vec_q   <= rsp_vec_d;
            rsp_sca_q   <= rsp_sca_d;
        end
    end

    assign vpe_vec1    = vec1_q;
    assign vpe_vec2    = vec2_q;
    assign vpe_sca1    = sca1_q;
    assign vpe_sca2    = sca2_q;
    assign vpe_mode    = mode_q;
    assign vpe_valid_o = (state_q == StIssue);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_vec     = rsp_vec_q;
    assign rsp_sca     = rsp_sca_q;
    assign busy        = (state_q != StIdle);
    assign timeout_err = terr_q;

endmodule
